i2c_target_regs: RTL and testbench

- I2C target (slave) that exposes a byte-addressed register space to the I2C bus.
- It is the responder end of the bus driven by i2c_master_axil. It is used on-chip as a loopback target and as an FPGA-hosted peripheral.
- Bus protocol: address byte, then a register-pointer byte, then data bytes. The pointer auto-increments; repeated-start reads are supported.
- Drives the bus with the same _i/_o/_t open-drain triplets as the master, so it connects to the same IOBUF style.

---
 rtl/i2c_target_pkg.sv | 21 ++
 rtl/i2c_line_cond.sv | 69 ++++++
 rtl/i2c_target_regs.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared state encoding and bus constants for the i2c_target_regs register target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWr,
    StWrAck,
    StRd,
    StRdAck,
    StIgnore
  } state_e;

  localparam int unsigned RwBitPos  = 0;
  localparam logic        AckLevel  = 1'b0;
  localparam logic        NackLevel = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C line: 2-flop synchronizer, optional persistence filter (I2C_FILTER_EN),
// then an edge register producing single-cycle rise/fall pulses.
module i2c_line_cond
  import i2c_target_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       cond;
  logic       prev_q;

  // Idle I2C lines are high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

`ifdef I2C_FILTER_EN
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  // Output follows the input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign cond = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign cond = sync_q[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= cond;
    end
  end

  assign level_o = cond;
  assign rise_o  = cond & ~prev_q;
  assign fall_o  = ~cond & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-addressed register space with an auto-incrementing pointer.
// Define I2C_FILTER_EN to add a FILTER_LEN-sample glitch filter on SCL and SDA.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned REG_ADDR_W = 8,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_scl_i,
  output logic                  i2c_scl_o,
  output logic                  i2c_scl_t,
  input  logic                  i2c_sda_i,
  output logic                  i2c_sda_o,
  output logic                  i2c_sda_t,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  busy
);

  localparam logic [REG_ADDR_W-1:0] PtrOne = REG_ADDR_W'(1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl_cond (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (i2c_scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda_cond (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (i2c_sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  state_e                state_q;
  logic [2:0]            bit_cnt_q;
  logic                  byte_done_q;  // 8 bits seen, next SCL fall starts the ACK phase
  logic                  rd_pend_q;    // read strobe issued, MSB goes out at next SCL fall
  logic                  rd_cap_q;
  logic                  rw_q;
  logic [7:0]            sh_q;
  logic [REG_ADDR_W-1:0] ptr_q;
  logic [REG_ADDR_W-1:0] reg_addr_q;
  logic [7:0]            reg_wdata_q;
  logic                  reg_we_q, reg_re_q, busy_q, sda_t_q;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {sh_q[6:0], sda_lvl};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_cap_q    <= 1'b0;
      rw_q        <= 1'b0;
      sh_q        <= 8'h00;
      ptr_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      sda_t_q     <= 1'b1;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      rd_cap_q <= reg_re_q;
      if (rd_cap_q) sh_q <= reg_rdata;

      if (start_det) begin
        state_q     <= StAddr;
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
        rd_pend_q   <= 1'b0;
        sda_t_q     <= 1'b1;
        busy_q      <= 1'b1;
      end else if (stop_det) begin
        state_q     <= StIdle;
        byte_done_q <= 1'b0;
        rd_pend_q   <= 1'b0;
        sda_t_q     <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StIgnore: ;
          StAddr, StPtr, StWr: begin
            if (scl_rise && !byte_done_q) begin
              sh_q      <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_done_q <= 1'b1;
                if (state_q == StAddr) begin
                  if (sh_q[6:0] == DEV_ADDR && sh_q[6:0] != 7'd0) begin
                    rw_q <= rx_byte[RwBitPos];
                  end else begin
                    state_q     <= StIgnore;
                    byte_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                  end
                end else if (state_q == StPtr) begin
                  ptr_q <= rx_byte[REG_ADDR_W-1:0];
                end else begin
                  reg_we_q    <= 1'b1;
                  reg_addr_q  <= ptr_q;
                  reg_wdata_q <= rx_byte;
                  ptr_q       <= ptr_q + PtrOne;
                end
              end
            end else if (scl_fall) begin
              if (byte_done_q) begin
                sda_t_q     <= AckLevel;
                byte_done_q <= 1'b0;
                state_q     <= (state_q == StAddr) ? StAddrAck :
                               (state_q == StPtr)  ? StPtrAck  : StWrAck;
              end else begin
                sda_t_q <= 1'b1;
              end
            end
          end
          StAddrAck, StRdAck: begin
            if (scl_rise && !rd_pend_q) begin
              if (state_q == StAddrAck && rw_q == 1'b0) begin
                state_q   <= StPtr;
                bit_cnt_q <= 3'd0;
              end else if (state_q == StRdAck && sda_lvl == NackLevel) begin
                state_q <= StIgnore;
              end else begin
                rd_pend_q <= 1'b1;
                reg_re_q  <= 1'b1;
                if (state_q == StRdAck) begin
                  ptr_q      <= ptr_q + PtrOne;
                  reg_addr_q <= ptr_q + PtrOne;
                end else begin
                  reg_addr_q <= ptr_q;
                end
              end
            end else if (scl_fall && rd_pend_q) begin
              rd_pend_q <= 1'b0;
              state_q   <= StRd;
              bit_cnt_q <= 3'd0;
              sda_t_q   <= sh_q[7];
            end
          end
          StPtrAck, StWrAck: begin
            if (scl_rise) begin
              state_q   <= StWr;
              bit_cnt_q <= 3'd0;
            end
          end
          StRd: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
            end else if (scl_fall) begin
              if (byte_done_q) begin
                sda_t_q     <= 1'b1;
                byte_done_q <= 1'b0;
                state_q     <= StRdAck;
              end else begin
                sh_q    <= {sh_q[6:0], 1'b0};
                sda_t_q <= sh_q[6];
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign i2c_scl_o = 1'b0;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_o = 1'b0;
  assign i2c_sda_t = sda_t_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master plus a register-strobe scoreboard.
module tb_i2c_target_regs;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_line, sda_line;
  logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re, busy;
  logic [7:0] reg_rdata = 8'h00;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_checks = 0;
  int  n_errors = 0;
  logic       ack;
  logic [7:0] rb;
  logic       busy_seen;
  logic       exp_busy_seen;

  always #5 clk = ~clk;

  assign scl_line = m_scl & (i2c_scl_t | i2c_scl_o);
  assign sda_line = m_sda & (i2c_sda_t | i2c_sda_o);

  // Register file model: read data is addr+1, valid the cycle after reg_re.
  always @(posedge clk) if (reg_re) reg_rdata <= reg_addr + 8'd1;

  i2c_target_regs dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl_i(scl_line),
    .i2c_scl_o(i2c_scl_o),
    .i2c_scl_t(i2c_scl_t),
    .i2c_sda_i(sda_line),
    .i2c_sda_o(i2c_sda_o),
    .i2c_sda_t(i2c_sda_t),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(1);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_scl = 1'b0; tick(1);
    end
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q / 2);
    a = sda_line; tick(Q / 2);
    m_scl = 1'b0; tick(1);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      m_scl = 1'b1; tick(Q / 2);
      b = {b[6:0], sda_line}; tick(Q / 2);
      m_scl = 1'b0; tick(1);
    end
    m_sda = nack; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_scl = 1'b0; tick(1);
    m_sda = 1'b1; tick(Q - 1);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reg_we || reg_re) begin
          n_checks++;
          assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL sb_unexpected observed we=%0b re=%0b addr=0x%0h expected=no strobe",
                   reg_we, reg_re, reg_addr);
          end
          if (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            check("sb_we", reg_we, ev.we);
            check("sb_re", reg_re, !ev.we);
            check("sb_addr", reg_addr, ev.addr);
            if (ev.we) check("sb_wdata", reg_wdata, ev.data);
          end
        end
      end
      begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    tick(4);
    @(negedge clk);
    check("rst_sda_t", i2c_sda_t, 1'b1);
    check("rst_scl_t", i2c_scl_t, 1'b1);
    check("rst_we", reg_we, 1'b0);
    check("rst_re", reg_re, 1'b0);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(Q);

    // 1: write two bytes from pointer 0x10, then read back from retained pointer 0x12
    push_wr(8'h10, 8'h5A);
    push_wr(8'h11, 8'h3C);
    i2c_start();
    check("t1_busy", busy, 1'b1);
    send_byte(8'hA0, ack); check("t1_ack_addr", ack, 1'b0);
    send_byte(8'h10, ack); check("t1_ack_ptr", ack, 1'b0);
    send_byte(8'h5A, ack); check("t1_ack_d0", ack, 1'b0);
    send_byte(8'h3C, ack); check("t1_ack_d1", ack, 1'b0);
    i2c_stop();
    check("t1_busy_stop", busy, 1'b0);
    push_rd(8'h12);
    i2c_start();
    send_byte(8'hA1, ack); check("t1_ack_rd", ack, 1'b0);
    recv_byte(1'b1, rb); check("t1_rd_byte", rb, 8'h13);
    i2c_stop();

    // 2: pointer 0x20, repeated START, read three bytes ACK/ACK/NACK
    i2c_start();
    send_byte(8'hA0, ack); check("t2_ack_addr", ack, 1'b0);
    send_byte(8'h20, ack); check("t2_ack_ptr", ack, 1'b0);
    push_rd(8'h20);
    push_rd(8'h21);
    push_rd(8'h22);
    i2c_start();
    send_byte(8'hA1, ack); check("t2_ack_rd", ack, 1'b0);
    recv_byte(1'b0, rb); check("t2_rd0", rb, 8'h21);
    recv_byte(1'b0, rb); check("t2_rd1", rb, 8'h22);
    recv_byte(1'b1, rb); check("t2_rd2", rb, 8'h23);
    check("t2_sda_released", i2c_sda_t, 1'b1);
    i2c_stop();

    // 3: foreign address is NACKed, then a matching write proceeds
    i2c_start();
    send_byte(8'hA4, ack); check("t3_nack", ack, 1'b1);
    check("t3_busy_drop", busy, 1'b0);
    i2c_stop();
    push_wr(8'h40, 8'h99);
    i2c_start();
    send_byte(8'hA0, ack); check("t3_ack_addr", ack, 1'b0);
    send_byte(8'h40, ack); check("t3_ack_ptr", ack, 1'b0);
    send_byte(8'h99, ack); check("t3_ack_d", ack, 1'b0);
    i2c_stop();

    // 4: pointer wraps 0xFF -> 0x00
    push_wr(8'hFF, 8'h11);
    push_wr(8'h00, 8'h22);
    i2c_start();
    send_byte(8'hA0, ack); check("t4_ack_addr", ack, 1'b0);
    send_byte(8'hFF, ack); check("t4_ack_ptr", ack, 1'b0);
    send_byte(8'h11, ack); check("t4_ack_d0", ack, 1'b0);
    send_byte(8'h22, ack); check("t4_ack_d1", ack, 1'b0);
    i2c_stop();

    // 5: reset while the target drives a 0 data bit (pointer 0x01 -> data 0x02)
    push_rd(8'h01);
    i2c_start();
    send_byte(8'hA1, ack); check("t5_ack_rd", ack, 1'b0);
    tick(Q / 2);
    check("t5_sda_driven", i2c_sda_t, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_sda_t", i2c_sda_t, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_addr", reg_addr, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    push_wr(8'h30, 8'h77);
    i2c_start();
    send_byte(8'hA0, ack); check("t5_ack_addr", ack, 1'b0);
    send_byte(8'h30, ack); check("t5_ack_ptr", ack, 1'b0);
    send_byte(8'h77, ack); check("t5_ack_d", ack, 1'b0);
    i2c_stop();

    // 6: 2-cycle SDA glitches with SCL high on an idle bus
`ifdef I2C_FILTER_EN
    exp_busy_seen = 1'b0;
`else
    exp_busy_seen = 1'b1;
`endif
    busy_seen = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk);
      m_sda = 1'b0;
      tick(2);
      m_sda = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (busy) busy_seen = 1'b1;
      end
    end
    check("t6_glitch_busy", busy_seen, exp_busy_seen);
    check("t6_busy_idle", busy, 1'b0);

    tick(Q);
    check("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
